// File: rtl/demux_1to16_16b.sv
// Registered 1-to-16 demultiplexer for 16-bit words: the selected output takes Y
// on each rising edge and every other output is cleared on the same edge.
module demux_1to16_16b (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] Y,
  input  logic        sel3,
  input  logic        sel2,
  input  logic        sel1,
  input  logic        sel0,
  output logic [15:0] X_0,
  output logic [15:0] X_1,
  output logic [15:0] X_2,
  output logic [15:0] X_3,
  output logic [15:0] X_4,
  output logic [15:0] X_5,
  output logic [15:0] X_6,
  output logic [15:0] X_7,
  output logic [15:0] X_8,
  output logic [15:0] X_9,
  output logic [15:0] X_10,
  output logic [15:0] X_11,
  output logic [15:0] X_12,
  output logic [15:0] X_13,
  output logic [15:0] X_14,
  output logic [15:0] X_15
);

  localparam int unsigned DATA_W = 16;
  localparam int unsigned SEL_W  = 4;
  localparam int unsigned N_OUT  = 16;

  logic [SEL_W-1:0]  sel;
  logic [DATA_W-1:0] x_q [N_OUT];

  assign sel = {sel3, sel2, sel1, sel0};

  // One register per destination; unselected destinations load zero.
  for (genvar n = 0; n < N_OUT; n++) begin : g_out
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        x_q[n] <= '0;
      end else if (sel == SEL_W'(n)) begin
        x_q[n] <= Y;
      end else begin
        x_q[n] <= '0;
      end
    end
  end

  assign X_0  = x_q[0];
  assign X_1  = x_q[1];
  assign X_2  = x_q[2];
  assign X_3  = x_q[3];
  assign X_4  = x_q[4];
  assign X_5  = x_q[5];
  assign X_6  = x_q[6];
  assign X_7  = x_q[7];
  assign X_8  = x_q[8];
  assign X_9  = x_q[9];
  assign X_10 = x_q[10];
  assign X_11 = x_q[11];
  assign X_12 = x_q[12];
  assign X_13 = x_q[13];
  assign X_14 = x_q[14];
  assign X_15 = x_q[15];

endmodule

// File: tb/tb_demux_1to16_16b.sv
// Bench for demux_1to16_16b: directed cases then random traffic with occasional
// asynchronous reset pulses, checked against an index+data reference model.
module tb_demux_1to16_16b;

  logic        clk;
  logic        rst;
  logic [15:0] y;
  logic [3:0]  s_drv;
  logic        sel3, sel2, sel1, sel0;
  logic [15:0] xo [16];

  int unsigned checks;
  int unsigned failures;

  // Reference: at most one destination (m_idx) holds m_data, everything else is zero.
  logic [3:0]  m_idx;
  logic [15:0] m_data;

  assign {sel3, sel2, sel1, sel0} = s_drv;

  demux_1to16_16b dut (
    .clk (clk),   .rst (rst),   .Y (y),
    .sel3(sel3),  .sel2(sel2),  .sel1(sel1),  .sel0(sel0),
    .X_0 (xo[0]), .X_1 (xo[1]), .X_2 (xo[2]), .X_3 (xo[3]),
    .X_4 (xo[4]), .X_5 (xo[5]), .X_6 (xo[6]), .X_7 (xo[7]),
    .X_8 (xo[8]), .X_9 (xo[9]), .X_10(xo[10]), .X_11(xo[11]),
    .X_12(xo[12]), .X_13(xo[13]), .X_14(xo[14]), .X_15(xo[15])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_all(input string tag);
    logic [15:0] exp;
    for (int n = 0; n < 16; n++) begin
      exp = (n == int'(m_idx)) ? m_data : 16'h0000;
      checks++;
      assert (xo[n] === exp) else begin
        failures++;
        $error("FAIL %s X_%0d observed=%h expected=%h", tag, n, xo[n], exp);
      end
    end
  endtask

  // Present inputs, take one edge, update the model and check just after the edge.
  task automatic step(input logic [15:0] yv, input logic [3:0] sv, input string tag);
    y     = yv;
    s_drv = sv;
    @(posedge clk);
    #1;
    if (!rst) begin
      m_idx  = sv;
      m_data = yv;
    end
    check_all(tag);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    y        = 16'h0000;
    s_drv    = 4'd0;
    m_idx    = 4'd0;
    m_data   = 16'h0000;

    // Reset asserted between edges clears at once and holds across edges.
    #1;
    y     = 16'hFFFF;
    s_drv = 4'd0;
    rst   = 1'b1;
    #1;
    m_data = 16'h0000;
    check_all("reset_imm");
    @(posedge clk); #1; check_all("reset_hold1");
    @(posedge clk); #1; check_all("reset_hold2");
    rst = 1'b0;

    step(16'h01E9, 4'd11, "route_x11");

    // Reselect: old output still visible before the edge, cleared on it.
    s_drv = 4'd5;
    #3;
    check_all("reselect_pre");
    step(16'h01E9, 4'd5, "reselect_x5");

    for (int i = 0; i < 16; i++)
      step(16'hA500 + 16'(i), 4'(i), $sformatf("sweep_%0d", i));

    // Async reset mid-stream discards the captured word without an edge.
    step(16'hBEEF, 4'd7, "load_x7");
    #2;
    rst    = 1'b1;
    #1;
    m_data = 16'h0000;
    check_all("async_rst_mid");
    #1;
    rst = 1'b0;
    #1;
    check_all("after_rst_fall");
    step(16'h4321, 4'd9, "post_rst_load");

    // Zero data, then input change between edges has no effect until the edge.
    step(16'h0000, 4'd3, "zero_data");
    y = 16'h1234;
    #3;
    check_all("hold_between_edges");
    step(16'h1234, 4'd3, "hold_then_load");

    // Random traffic with occasional mid-cycle reset pulses.
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 19) == 0) begin
        #2;
        rst = 1'b1;
        #1;
        m_data = 16'h0000;
        check_all("rand_rst");
        #1;
        rst = 1'b0;
      end
      if ($urandom_range(0, 7) == 0) begin
        y     = 16'($urandom);
        s_drv = 4'($urandom);
        #2;
        check_all("rand_glitch_hold");
      end
      step(16'($urandom), 4'($urandom), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
